lzss_block_sched: RTL and testbench
===================================

LZSS_BLOCK_SCHED -- requirements
Module: lzss_block_sched

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, meaning the coefficient byte width.
REQ-002 SHALL have parameter BLOCK_LEN, default 64, meaning the beats per block (one zig-zag 8x8 block).
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, meaning the idle cycles after the end marker.
REQ-004 SHALL have parameter END_MARKER, default 8'hFF, meaning the block terminator word.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1, meaning the single clock (all logic on rising edge).
REQ-007 SHALL have port rst, input, 1, meaning the synchronous active-high reset.
REQ-008 SHALL have ports s0_valid, s1_valid, input, 1, meaning requester n has a beat.
REQ-009 SHALL have ports s0_data, s1_data, input, WORD_SIZE, meaning requester n beat data.
REQ-010 SHALL have ports s0_ready, s1_ready, output, 1, meaning beat accepted when valid&ready.
REQ-011 SHALL have ports enc_w_en, output, 1, and enc_data, output, WORD_SIZE, meaning the encoder write strobe and data; both are registered.
REQ-012 SHALL have ports enc_o_ready, input, 1, and enc_data_o, input, WORD_SIZE+1, meaning the encoder output strobe and word.
REQ-013 SHALL have ports out_valid, output, 1; out_data, output, WORD_SIZE+1; and out_src, output, 1, meaning the tagged encoder output.
REQ-014 SHALL have ports busy, output, 1; blk_done, output, 1; and blk_out_words, output, 8, meaning the block status.

Function
REQ-015 SHALL implement the FSM states IDLE, STREAM, MARK and DRAIN.
REQ-016 SHALL, in IDLE with any s_valid high, register owner on the edge and go to STREAM: round-robin, pointer ptr wins when both are valid, otherwise the single valid requester wins; no beat is accepted in IDLE.
REQ-017 SHALL, in STREAM, drive s_ready=1 for the owner only and s_ready=0 for the other requester.
REQ-018 SHALL drive s_ready=0 for both requesters in IDLE, MARK and DRAIN.
REQ-019 SHALL, for a beat accepted on edge k, present enc_w_en=1 and enc_data=beat during the cycle after edge k.
REQ-020 SHALL set enc_w_en=0 on a STREAM cycle where owner valid is low; stalls pass through unchanged and the beat counter holds.
REQ-021 SHALL use a beat counter of clog2(BLOCK_LEN)+1 bits, cleared on grant and incremented per accepted beat.
REQ-022 SHALL go to MARK on the edge accepting beat BLOCK_LEN-1.
REQ-023 SHALL, in MARK, register enc_w_en=1 and enc_data=END_MARKER and go to DRAIN on that edge; the marker is exactly one cycle wide.
REQ-024 SHALL, in DRAIN, hold enc_w_en=0 for DRAIN_CYCLES cycles, then pulse blk_done for one cycle, set ptr to ~owner, and return to IDLE.
REQ-025 SHALL have busy=1 in STREAM, MARK and DRAIN, and busy=0 in IDLE.
REQ-026 SHALL drive out_valid=enc_o_ready, out_data=enc_data_o and out_src=owner combinationally; owner changes only on grant.
REQ-027 SHALL count enc_o_ready cycles from grant through the final DRAIN cycle inclusive, saturating at 255.
REQ-028 SHALL present the REQ-027 count on blk_out_words during the blk_done cycle and hold it until the next blk_done.
REQ-029 SHALL keep the owner granted until DRAIN completes if the owner drops valid mid-block; there is no timeout and no preemption.
REQ-030 SHALL ignore requests from the non-owner during a block; they are served on the next IDLE.
REQ-031 SHALL grant requester 0 after reset when both requesters request.

Reset
REQ-032 SHALL, on rst high at an edge, force the FSM to IDLE and clear enc_w_en, enc_data, ptr, owner, the beat counter, blk_done and blk_out_words to 0.
REQ-033 SHALL drop enc_w_en to 0 on the first edge of a reset asserted mid-block; the partial block is abandoned and no marker is sent.
REQ-034 SHALL hold s_ready=0 and busy=0 while rst is high.

Verification
REQ-035 SHALL cover a single block: s0 streams 64 beats with valid held high, s1 idle -> enc_w_en high for 64 consecutive cycles with data in order, then 0xFF on the next cycle, then 4 cycles of enc_w_en=0, then blk_done=1 for one cycle with ptr=1.
REQ-036 SHALL cover arbitration: both valid after reset -> s0 is served first; at the next IDLE with both valid -> s1 is granted, and s0_ready=0 throughout s1's block.
REQ-037 SHALL cover stalls: s0 deasserts valid for 3 cycles at beat 10 -> 3-cycle gap in enc_w_en, 64 data beats total, marker after beat 63 only.
REQ-038 SHALL cover output tagging: encoder emits 23 o_ready pulses during an s1 block -> 23 out_valid cycles with out_src=1 and blk_out_words=23 at blk_done.
REQ-039 SHALL cover reset mid-stream: rst high at beat 30 -> next cycle enc_w_en=0, busy=0, no 0xFF emitted; after release, s1-only request is granted and blk_out_words=0.
REQ-040 SHALL cover back-to-back blocks: s0 valid continuously -> exactly one IDLE cycle between blk_done and the next grant to s0.

Source files
------------

// File: rtl/lzss_block_sched.sv
// Two-requester block scheduler for an LZSS encoder: grants one source per 64-beat block,
// appends an end marker, drains the pipe, and tags encoder output with the block owner.
module lzss_block_sched #(
  parameter int unsigned          WORD_SIZE    = 8,
  parameter int unsigned          BLOCK_LEN    = 64,
  parameter int unsigned          DRAIN_CYCLES = 4,
  parameter logic [WORD_SIZE-1:0] END_MARKER   = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s0_valid,
  input  logic                 s1_valid,
  input  logic [WORD_SIZE-1:0] s0_data,
  input  logic [WORD_SIZE-1:0] s1_data,
  output logic                 s0_ready,
  output logic                 s1_ready,
  output logic                 enc_w_en,
  output logic [WORD_SIZE-1:0] enc_data,
  input  logic                 enc_o_ready,
  input  logic [WORD_SIZE:0]   enc_data_o,
  output logic                 out_valid,
  output logic [WORD_SIZE:0]   out_data,
  output logic                 out_src,
  output logic                 busy,
  output logic                 blk_done,
  output logic [7:0]           blk_out_words
);

  localparam int unsigned CntW   = $clog2(BLOCK_LEN) + 1;
  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1) + 1;
  localparam logic [CntW-1:0]   LastBeat  = CntW'(BLOCK_LEN - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {StIdle, StStream, StMark, StDrain} state_e;

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   ptr_q, ptr_d;
  logic [CntW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [DrainW-1:0]      drain_cnt_q, drain_cnt_d;
  logic                   enc_w_en_q, enc_w_en_d;
  logic [WORD_SIZE-1:0]   enc_data_q, enc_data_d;
  logic [7:0]             out_cnt_q, out_cnt_d;
  logic                   blk_done_q, blk_done_d;
  logic [7:0]             blk_out_words_q, blk_out_words_d;

  logic                   owner_valid;
  logic [WORD_SIZE-1:0]   owner_data;
  logic                   accept;
  logic                   any_req;
  logic                   drain_last;

  assign owner_valid = owner_q ? s1_valid : s0_valid;
  assign owner_data  = owner_q ? s1_data : s0_data;
  assign accept      = (state_q == StStream) && owner_valid;
  assign any_req     = s0_valid || s1_valid;
  assign drain_last  = (drain_cnt_q == DrainLast);

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      owner_q         <= 1'b0;
      ptr_q           <= 1'b0;
      beat_cnt_q      <= '0;
      drain_cnt_q     <= '0;
      enc_w_en_q      <= 1'b0;
      enc_data_q      <= '0;
      out_cnt_q       <= '0;
      blk_done_q      <= 1'b0;
      blk_out_words_q <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      ptr_q           <= ptr_d;
      beat_cnt_q      <= beat_cnt_d;
      drain_cnt_q     <= drain_cnt_d;
      enc_w_en_q      <= enc_w_en_d;
      enc_data_q      <= enc_data_d;
      out_cnt_q       <= out_cnt_d;
      blk_done_q      <= blk_done_d;
      blk_out_words_q <= blk_out_words_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_req) state_d = StStream;
      StStream: if (accept && (beat_cnt_q == LastBeat)) state_d = StMark;
      StMark:   state_d = StDrain;
      StDrain:  if (drain_last) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next values
  always_comb begin
    owner_d         = owner_q;
    ptr_d           = ptr_q;
    beat_cnt_d      = beat_cnt_q;
    drain_cnt_d     = drain_cnt_q;
    enc_w_en_d      = 1'b0;
    enc_data_d      = enc_data_q;
    out_cnt_d       = out_cnt_q;
    blk_done_d      = 1'b0;
    blk_out_words_d = blk_out_words_q;

    if ((state_q != StIdle) && enc_o_ready && (out_cnt_q != 8'hFF)) begin
      out_cnt_d = out_cnt_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          // Pointer only matters on a tie; a lone requester always wins.
          owner_d    = (s0_valid && s1_valid) ? ptr_q : s1_valid;
          beat_cnt_d = '0;
          out_cnt_d  = '0;
        end
      end
      StStream: begin
        if (accept) begin
          enc_w_en_d = 1'b1;
          enc_data_d = owner_data;
          beat_cnt_d = beat_cnt_q + CntW'(1);
        end
      end
      StMark: begin
        enc_w_en_d  = 1'b1;
        enc_data_d  = END_MARKER;
        drain_cnt_d = '0;
      end
      StDrain: begin
        if (drain_last) begin
          blk_done_d      = 1'b1;
          ptr_d           = ~owner_q;
          // Includes an output word arriving in this final drain cycle.
          blk_out_words_d = out_cnt_d;
        end else begin
          drain_cnt_d = drain_cnt_q + DrainW'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs; handshakes and busy are masked while reset is held
  always_comb begin
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    busy     = 1'b0;
    if (!rst) begin
      busy = (state_q != StIdle);
      if (state_q == StStream) begin
        s0_ready = !owner_q;
        s1_ready = owner_q;
      end
    end
  end

  assign enc_w_en      = enc_w_en_q;
  assign enc_data      = enc_data_q;
  assign out_valid     = enc_o_ready;
  assign out_data      = enc_data_o;
  assign out_src       = owner_q;
  assign blk_done      = blk_done_q;
  assign blk_out_words = blk_out_words_q;

endmodule

// File: tb/tb_lzss_block_sched.sv
// Directed bench for lzss_block_sched: encoder-write words are checked against a queue of
// expected words filled as beats are driven; handshake/status timing checked per cycle.
module tb_lzss_block_sched;

  localparam int          W         = 8;
  localparam int          BLOCK_LEN = 64;
  localparam int          DRAIN     = 4;
  localparam logic [W-1:0] END_MARK = 8'hFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         s0_valid, s1_valid;
  logic [W-1:0] s0_data, s1_data;
  logic         s0_ready, s1_ready;
  logic         enc_w_en;
  logic [W-1:0] enc_data;
  logic         enc_o_ready;
  logic [W:0]   enc_data_o;
  logic         out_valid;
  logic [W:0]   out_data;
  logic         out_src;
  logic         busy;
  logic         blk_done;
  logic [7:0]   blk_out_words;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  always #5 clk = ~clk;

  lzss_block_sched dut (
    .clk           (clk),
    .rst           (rst),
    .s0_valid      (s0_valid),
    .s1_valid      (s1_valid),
    .s0_data       (s0_data),
    .s1_data       (s1_data),
    .s0_ready      (s0_ready),
    .s1_ready      (s1_ready),
    .enc_w_en      (enc_w_en),
    .enc_data      (enc_data),
    .enc_o_ready   (enc_o_ready),
    .enc_data_o    (enc_data_o),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_src       (out_src),
    .busy          (busy),
    .blk_done      (blk_done),
    .blk_out_words (blk_out_words)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every encoder write must match the next expected word, in order.
  always @(negedge clk) begin
    if (enc_w_en === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL enc_word_unexpected: observed %0h required no write", enc_data);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        n_cmp++;
        assert (enc_data === mon_exp) else begin
          n_err++;
          $error("FAIL enc_word: observed %0h required %0h", enc_data, mon_exp);
        end
      end
    end
  end

  // Called in the first STREAM cycle after a grant; returns in the blk_done cycle.
  task automatic stream_block(input bit src, input int stall_at, input int stall_len,
                              input int n_pulses, input bit drain_pulse);
    int i;
    int stall_cnt;
    int pulse_cnt;
    bit prev_acc;
    bit stalled;
    logic [W-1:0] d;
    i = 0; stall_cnt = 0; pulse_cnt = 0; prev_acc = 1'b0;
    while (i < BLOCK_LEN) begin
      stalled = (i == stall_at) && (stall_cnt < stall_len);
      d = src ? W'(8'hA0 ^ (i * 5)) : W'(i * 3 + 1);
      if (src) begin s1_valid = !stalled; s1_data = d; end
      else     begin s0_valid = !stalled; s0_data = d; end
      enc_o_ready = !stalled && (i % 2 == 0) && (pulse_cnt < n_pulses);
      enc_data_o  = 9'(i) | 9'h100;
      if (enc_o_ready) pulse_cnt++;
      #1;
      check("owner_ready", src ? s1_ready : s0_ready, 1);
      check("other_ready", src ? s0_ready : s1_ready, 0);
      check("busy_stream", busy, 1);
      check("out_src", out_src, src);
      check("out_valid", out_valid, enc_o_ready);
      check("out_data", out_data, enc_data_o);
      check("w_en_stream", enc_w_en, prev_acc);
      if (!stalled) exp_q.push_back(d);
      prev_acc = !stalled;
      step();
      if (stalled) stall_cnt++;
      else i++;
    end
    enc_o_ready = 1'b0;
    #1;
    check("w_en_last_beat", enc_w_en, 1);
    check("s0_ready_mark", s0_ready, 0);
    check("s1_ready_mark", s1_ready, 0);
    check("busy_mark", busy, 1);
    exp_q.push_back(END_MARK);
    step();
    check("marker_w_en", enc_w_en, 1);
    check("marker_data", enc_data, END_MARK);
    for (int k = 0; k < DRAIN; k++) begin
      step();
      check("w_en_drain", enc_w_en, 0);
      check("busy_drain", busy, 1);
      check("s0_ready_drain", s0_ready, 0);
      check("s1_ready_drain", s1_ready, 0);
      check("blk_done_early", blk_done, 0);
      if (k == DRAIN - 1) enc_o_ready = drain_pulse;
    end
    step();
    enc_o_ready = 1'b0;
    check("blk_done", blk_done, 1);
    check("busy_done", busy, 0);
    check("blk_out_words", blk_out_words, n_pulses + int'(drain_pulse));
    check("s0_ready_done", s0_ready, 0);
    check("s1_ready_done", s1_ready, 0);
  endtask

  initial begin
    rst = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_data = '0; s1_data = '0;
    enc_o_ready = 1'b0; enc_data_o = '0;
    step();
    step();

    // Reset state, with both requesters already asking.
    s0_valid = 1'b1; s1_valid = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_s0_ready", s0_ready, 0);
    check("rst_s1_ready", s1_ready, 0);
    check("rst_w_en", enc_w_en, 0);
    check("rst_enc_data", enc_data, 0);
    check("rst_blk_done", blk_done, 0);
    check("rst_blk_words", blk_out_words, 0);
    rst = 1'b0;
    #1;
    check("idle_busy", busy, 0);
    check("idle_s0_ready", s0_ready, 0);
    check("idle_s1_ready", s1_ready, 0);
    step();

    // Block 1: tie after reset goes to s0; no encoder output.
    stream_block(1'b0, -1, 0, 0, 1'b0);
    // Block 2: tie again now goes to s1; 22 stream pulses plus one in the last drain cycle.
    step();
    stream_block(1'b1, -1, 0, 22, 1'b1);
    // Block 3: s0 alone with a 3-cycle stall at beat 10.
    s1_valid = 1'b0;
    step();
    stream_block(1'b0, 10, 3, 5, 1'b0);
    // s0 kept valid: regranted after exactly one idle (blk_done) cycle.
    step();
    check("b2b_s0_ready", s0_ready, 1);
    check("b2b_busy", busy, 1);

    // Block 4: reset lands while beat 30 is offered.
    for (int i = 0; i < 30; i++) begin
      s0_valid = 1'b1;
      s0_data  = W'(i * 7 + 2);
      #1;
      check("w_en_pre_rst", enc_w_en, i > 0);
      exp_q.push_back(s0_data);
      step();
    end
    rst = 1'b1;
    s0_data = 8'hEE;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_s0_ready", s0_ready, 0);
    step();
    check("post_rst_w_en", enc_w_en, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_blk_done", blk_done, 0);
    check("post_rst_blk_words", blk_out_words, 0);
    rst = 1'b0;
    s0_valid = 1'b0;
    s1_valid = 1'b1;
    #1;
    check("post_rst_idle_s1_ready", s1_ready, 0);
    step();
    check("s1_grant_ready", s1_ready, 1);
    check("s1_grant_src", out_src, 1);
    check("s1_grant_busy", busy, 1);

    // Owner goes quiet mid-block; s0 must stay locked out.
    s1_valid = 1'b0;
    s0_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("hold_s1_ready", s1_ready, 1);
      check("hold_s0_ready", s0_ready, 0);
      check("hold_busy", busy, 1);
      check("hold_w_en", enc_w_en, 0);
      step();
    end
    stream_block(1'b1, -1, 0, 0, 1'b0);
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    step();
    step();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
